wb_ctrl_pipe: RTL and testbench
===============================

# wb_ctrl_pipe

Parametrised writeback control pipeline between the MEM stage and the register-file write port. Decodes the MEM-stage opcode into writeback select and register write enable, then carries that control through `MEM_LAT` register stages so it lines up with variable-latency data-memory returns. When a load reaches writeback before its data is back, the block freezes and stalls upstream.

## Interface
- `MEM_LAT`, 1, cycles from MEM-stage acceptance to writeback; legal range 1..4
- `RD_W`, 5, destination register index width
- `clk` input 1 — sole clock, rising edge
- `rst_n` input 1 — asynchronous, active-low reset
- `in_valid` input 1 — MEM-stage instruction present
- `in_opcode` input 7 — RV32 opcode
- `in_funct3` input 3 — funct3, carried through for load extension and CSR decode
- `in_rd` input RD_W — destination register
- `mem_resp_valid` input 1 — load data valid this cycle
- `stall_o` output 1 — upstream must hold its instruction
- `wb_valid` output 1 — writeback slot valid this cycle
- `wb_sel` output 2 — 00 mem, 01 ALU, 10 PC+4, 11 CSR
- `wb_regwen` output 1 — register-file write enable
- `wb_rd` output RD_W — write address
- `wb_funct3` output 3 — funct3 of the writing instruction

## Operation
- Decode at input: ARI_RTYPE/ARI_ITYPE/AUIPC/LUI → sel 01, wen 1; LOAD → sel 00, wen 1; JAL/JALR → sel 10, wen 1; SYSTEM → sel 11, wen = (funct3 != 0); STORE, BRANCH, and any other opcode → sel 00, wen 0.
- `in_rd == 0` forces wen 0. The entry still flows and `wb_valid` still asserts.
- Entry fields: valid, sel, wen, is_load, rd, funct3.
- Pipeline: `stage[0]` .. `stage[MEM_LAT-1]`. The head is `stage[MEM_LAT-1]`.
- `freeze = head.valid & head.is_load & ~mem_resp_valid`.
- `stall_o = freeze`, combinational.
- When not frozen, every edge shifts the pipeline by one. `stage[0]` takes the decoded input with valid = `in_valid`.
- When frozen, all stages hold and the input is not captured.
- Outputs are combinational from the head:
  - `wb_valid = head.valid & ~freeze`
  - `wb_regwen = wb_valid & head.wen`
  - `wb_sel`, `wb_rd`, `wb_funct3` = head fields
- If `mem_resp_valid` arrives while the head is not a valid load, it is ignored.
- Bubbles (`in_valid` = 0) propagate as valid = 0 entries. They never freeze.

## Timing
- Reset (async assert, sync-release behaviour not required): all stage valid bits 0, all fields 0. As a result `stall_o`=0, `wb_valid`=0, `wb_regwen`=0, `wb_sel`=00, `wb_rd`=0, `wb_funct3`=0.
- Latency: an instruction accepted at edge t is at the head, with outputs driven, during the cycle after edge t+MEM_LAT-1. That is MEM_LAT cycles after acceptance.
- Load at the head with `mem_resp_valid`=1 in the same cycle: `wb_valid`=1 that cycle, no freeze.
- Load at the head without a response: freeze for as many cycles as needed. Release happens in the same cycle `mem_resp_valid` rises.
- Back-to-back loads: each waits independently for its own `mem_resp_valid` at the head.
- Reset mid-freeze: every entry is discarded immediately and `stall_o` drops asynchronously.
- Throughput: one instruction per cycle when no freeze occurs.

## Configuration
- `WB_CTRL_HAZARD_EN` defined: adds inputs `rs1_q`, `rs2_q` (RD_W each) and outputs `haz_rs1`, `haz_rs2`.
  - `haz_rsN` = 1 iff some valid stage, or the frozen head, has is_load=1, wen=1, and rd == rs and nonzero.
  - These outputs are combinational and used for load-use stall.
- Not defined: the ports and comparators are absent. Functional behaviour is otherwise identical.

## Structure
- Shared package `wb_ctrl_pkg`:
  - opcode constants (reuse the existing `OPC_*` defines)
  - WBSel encodings: `WB_SEL_MEM`, `WB_SEL_ALU`, `WB_SEL_PC4`, `WB_SEL_CSR`
  - entry struct/field widths
- Sub-module `wb_decode`: purely combinational opcode/funct3/rd → {sel, wen, is_load}. It is instantiated once at the input.

## Test plan
- Reset: hold `rst_n`=0 with `in_valid`=1 → all outputs 0. Release, send R-type rd=5 with MEM_LAT=1 → next cycle `wb_valid`=1, `wb_sel`=01, `wb_regwen`=1, `wb_rd`=5.
- Load wait, MEM_LAT=2: LOAD rd=7 with `mem_resp_valid` low for 3 cycles at the head → `stall_o`=1 for 3 cycles and `wb_valid`=0. On the response cycle: `wb_valid`=1, `wb_sel`=00, `wb_rd`=7, `stall_o`=0.
- Decode sweep: STORE → `wb_regwen`=0. BRANCH → `wb_regwen`=0. JAL rd=1 → sel 10, wen 1. CSRRW rd=3 → sel 11, wen 1. ECALL (funct3=0) → wen 0. ADDI rd=0 → `wb_valid`=1, `wb_regwen`=0.
- Stream, MEM_LAT=4: 8 back-to-back ALU ops → outputs in order, 4-cycle latency, no stalls. Inject a bubble → `wb_valid`=0 in exactly one cycle.
- Async reset asserted mid-freeze → `stall_o` and `wb_valid` drop before the next edge. The stalled load never writes back.
- `WB_CTRL_HAZARD_EN`: LOAD rd=9 in flight, `rs1_q`=9 → `haz_rs1`=1. `rs2_q`=0 → `haz_rs2`=0. Once the load retires → `haz_rs1`=0.

Source files
------------

// File: rtl/wb_ctrl_pkg.sv
// Shared definitions for the writeback control pipeline: RV32 opcodes,
// writeback-select encodings and the decoded control bundle.
package wb_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam int OPC_W = 7;
    localparam int F3_W  = 3;
    localparam int SEL_W = 2;

    typedef enum logic [SEL_W-1:0] {
        WB_SEL_MEM = 2'b00,
        WB_SEL_ALU = 2'b01,
        WB_SEL_PC4 = 2'b10,
        WB_SEL_CSR = 2'b11
    } wb_sel_e;

    // Decoded writeback control for one instruction
    typedef struct packed {
        wb_sel_e sel;
        logic    wen;
        logic    is_load;
    } wb_dec_t;

endpackage

// File: rtl/wb_ctrl_pipe_decode.sv
// wb_decode: combinational opcode/funct3/rd -> writeback select, write
// enable and load flag. Writes to x0 are suppressed here so the pipeline
// never has to look at rd for enable purposes.
module wb_decode
    import wb_ctrl_pkg::*;
#(
    parameter int RD_W = 5
) (
    input  logic [OPC_W-1:0] i_opcode,
    input  logic [F3_W-1:0]  i_funct3,
    input  logic [RD_W-1:0]  i_rd,
    output wb_dec_t          o_dec
);

    // Opcode class decode, then x0 write suppression
    always_comb begin
        o_dec.sel     = WB_SEL_MEM;
        o_dec.wen     = 1'b0;
        o_dec.is_load = 1'b0;
        case (i_opcode)
            OPC_ARI_RTYPE, OPC_ARI_ITYPE, OPC_AUIPC, OPC_LUI: begin
                o_dec.sel = WB_SEL_ALU;
                o_dec.wen = 1'b1;
            end
            OPC_LOAD: begin
                o_dec.wen     = 1'b1;
                o_dec.is_load = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                o_dec.sel = WB_SEL_PC4;
                o_dec.wen = 1'b1;
            end
            OPC_SYSTEM: begin
                // funct3 == 0 is ECALL/EBREAK/xRET: no register result
                o_dec.sel = WB_SEL_CSR;
                o_dec.wen = (i_funct3 != '0);
            end
            default: ;
        endcase
        // A load to x0 still has to wait for its data, so only wen drops
        if (i_rd == '0) o_dec.wen = 1'b0;
    end

endmodule

// File: rtl/wb_ctrl_pipe.sv
// wb_ctrl_pipe: carries decoded writeback control through MEM_LAT stages
// and freezes when a load reaches the head before its data returns.
// Optional feature macro WB_CTRL_HAZARD_EN adds load-use hazard compares
// (rs1_q/rs2_q in, haz_rs1/haz_rs2 out).
module wb_ctrl_pipe
    import wb_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int RD_W    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [OPC_W-1:0]  in_opcode,
    input  logic [F3_W-1:0]   in_funct3,
    input  logic [RD_W-1:0]   in_rd,
    input  logic              mem_resp_valid,
`ifdef WB_CTRL_HAZARD_EN
    input  logic [RD_W-1:0]   rs1_q,
    input  logic [RD_W-1:0]   rs2_q,
    output logic              haz_rs1,
    output logic              haz_rs2,
`endif
    output logic              stall_o,
    output logic              wb_valid,
    output logic [SEL_W-1:0]  wb_sel,
    output logic              wb_regwen,
    output logic [RD_W-1:0]   wb_rd,
    output logic [F3_W-1:0]   wb_funct3
);

    localparam int HEAD = MEM_LAT - 1;

    wb_dec_t w_dec;
    logic    w_freeze;

    logic             r_vld [MEM_LAT];
    logic [SEL_W-1:0] r_sel [MEM_LAT];
    logic             r_wen [MEM_LAT];
    logic             r_ld  [MEM_LAT];
    logic [RD_W-1:0]  r_rd  [MEM_LAT];
    logic [F3_W-1:0]  r_f3  [MEM_LAT];

    wb_decode #(.RD_W(RD_W)) u_dec (
        .i_opcode (in_opcode),
        .i_funct3 (in_funct3),
        .i_rd     (in_rd),
        .o_dec    (w_dec)
    );

    assign w_freeze = r_vld[HEAD] & r_ld[HEAD] & ~mem_resp_valid;

    // Shift register of control entries; holds in place while frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                r_vld[i] <= 1'b0;
                r_sel[i] <= '0;
                r_wen[i] <= 1'b0;
                r_ld[i]  <= 1'b0;
                r_rd[i]  <= '0;
                r_f3[i]  <= '0;
            end
        end else if (!w_freeze) begin
            r_vld[0] <= in_valid;
            r_sel[0] <= w_dec.sel;
            r_wen[0] <= w_dec.wen;
            r_ld[0]  <= w_dec.is_load;
            r_rd[0]  <= in_rd;
            r_f3[0]  <= in_funct3;
            for (int i = 1; i < MEM_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_sel[i] <= r_sel[i-1];
                r_wen[i] <= r_wen[i-1];
                r_ld[i]  <= r_ld[i-1];
                r_rd[i]  <= r_rd[i-1];
                r_f3[i]  <= r_f3[i-1];
            end
        end
    end

    assign stall_o   = w_freeze;
    assign wb_valid  = r_vld[HEAD] & ~w_freeze;
    assign wb_regwen = wb_valid & r_wen[HEAD];
    assign wb_sel    = r_sel[HEAD];
    assign wb_rd     = r_rd[HEAD];
    assign wb_funct3 = r_f3[HEAD];

`ifdef WB_CTRL_HAZARD_EN
    // Any in-flight load (including a frozen head) targeting rs1/rs2
    always_comb begin
        haz_rs1 = 1'b0;
        haz_rs2 = 1'b0;
        for (int i = 0; i < MEM_LAT; i++) begin
            if (r_vld[i] && r_ld[i] && r_wen[i]) begin
                if (r_rd[i] == rs1_q && rs1_q != '0) haz_rs1 = 1'b1;
                if (r_rd[i] == rs2_q && rs2_q != '0) haz_rs2 = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_wb_ctrl_pipe.sv
// Directed bench for wb_ctrl_pipe: three instances (MEM_LAT 1, 2, 4) share
// one stimulus; each scenario checks the instance whose latency it targets.
module tb_wb_ctrl_pipe;
    import wb_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [6:0] in_opcode;
    logic [2:0] in_funct3;
    logic [4:0] in_rd;
    logic       mem_resp_valid;

    logic       s1_stall, s1_vld, s1_wen;
    logic [1:0] s1_sel;
    logic [4:0] s1_rd;
    logic [2:0] s1_f3;
    logic       s2_stall, s2_vld, s2_wen;
    logic [1:0] s2_sel;
    logic [4:0] s2_rd;
    logic [2:0] s2_f3;
    logic       s4_stall, s4_vld, s4_wen;
    logic [1:0] s4_sel;
    logic [4:0] s4_rd;
    logic [2:0] s4_f3;
`ifdef WB_CTRL_HAZARD_EN
    logic [4:0] rs1_q, rs2_q;
    logic       h1_rs1, h1_rs2, h2_rs1, h2_rs2, h4_rs1, h4_rs2;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_ctrl_pipe #(.MEM_LAT(1), .RD_W(5)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_rd(in_rd), .mem_resp_valid(mem_resp_valid),
`ifdef WB_CTRL_HAZARD_EN
        .rs1_q(rs1_q), .rs2_q(rs2_q), .haz_rs1(h1_rs1), .haz_rs2(h1_rs2),
`endif
        .stall_o(s1_stall), .wb_valid(s1_vld), .wb_sel(s1_sel),
        .wb_regwen(s1_wen), .wb_rd(s1_rd), .wb_funct3(s1_f3)
    );

    wb_ctrl_pipe #(.MEM_LAT(2), .RD_W(5)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_rd(in_rd), .mem_resp_valid(mem_resp_valid),
`ifdef WB_CTRL_HAZARD_EN
        .rs1_q(rs1_q), .rs2_q(rs2_q), .haz_rs1(h2_rs1), .haz_rs2(h2_rs2),
`endif
        .stall_o(s2_stall), .wb_valid(s2_vld), .wb_sel(s2_sel),
        .wb_regwen(s2_wen), .wb_rd(s2_rd), .wb_funct3(s2_f3)
    );

    wb_ctrl_pipe #(.MEM_LAT(4), .RD_W(5)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_opcode(in_opcode),
        .in_funct3(in_funct3), .in_rd(in_rd), .mem_resp_valid(mem_resp_valid),
`ifdef WB_CTRL_HAZARD_EN
        .rs1_q(rs1_q), .rs2_q(rs2_q), .haz_rs1(h4_rs1), .haz_rs2(h4_rs2),
`endif
        .stall_o(s4_stall), .wb_valid(s4_vld), .wb_sel(s4_sel),
        .wb_regwen(s4_wen), .wb_rd(s4_rd), .wb_funct3(s4_f3)
    );

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] opc,
                         input logic [2:0] f3, input logic [4:0] rd);
        in_valid  = v;
        in_opcode = opc;
        in_funct3 = f3;
        in_rd     = rd;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        mem_resp_valid = 1'b0;
        drive(1'b0, 7'd0, 3'd0, 5'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        mem_resp_valid = 1'b0;
        drive(1'b1, OPC_ARI_RTYPE, 3'd0, 5'd5);
        tick();
        tick();
        checks++; if ({s1_stall, s1_vld, s1_wen, s1_sel, s1_rd, s1_f3} !== 13'd0) begin
            errors++; $display("FAIL rst_outs_lat1 got=%h exp=0", {s1_stall, s1_vld, s1_wen, s1_sel, s1_rd, s1_f3}); end
        checks++; if ({s2_stall, s2_vld, s2_wen, s2_sel, s2_rd, s2_f3} !== 13'd0) begin
            errors++; $display("FAIL rst_outs_lat2 got=%h exp=0", {s2_stall, s2_vld, s2_wen, s2_sel, s2_rd, s2_f3}); end
        checks++; if ({s4_stall, s4_vld, s4_wen, s4_sel, s4_rd, s4_f3} !== 13'd0) begin
            errors++; $display("FAIL rst_outs_lat4 got=%h exp=0", {s4_stall, s4_vld, s4_wen, s4_sel, s4_rd, s4_f3}); end
        rst_n = 1'b1;
        tick();
        drive(1'b0, 7'd0, 3'd0, 5'd0);
        checks++; if (s1_vld !== 1'b1) begin errors++; $display("FAIL rst_first_vld got=%b exp=1", s1_vld); end
        checks++; if (s1_sel !== 2'b01) begin errors++; $display("FAIL rst_first_sel got=%b exp=01", s1_sel); end
        checks++; if (s1_wen !== 1'b1) begin errors++; $display("FAIL rst_first_wen got=%b exp=1", s1_wen); end
        checks++; if (s1_rd !== 5'd5) begin errors++; $display("FAIL rst_first_rd got=%0d exp=5", s1_rd); end
        checks++; if (s1_stall !== 1'b0) begin errors++; $display("FAIL rst_first_stall got=%b exp=0", s1_stall); end
    endtask

    task automatic test_decode();
        logic [6:0] opc [11];
        logic [2:0] f3  [11];
        logic [4:0] rd  [11];
        logic [1:0] esel[11];
        logic       ewen[11];
        opc[0]  = OPC_STORE;     f3[0]  = 3'd2; rd[0]  = 5'd4; esel[0]  = 2'b00; ewen[0]  = 1'b0;
        opc[1]  = OPC_BRANCH;    f3[1]  = 3'd0; rd[1]  = 5'd2; esel[1]  = 2'b00; ewen[1]  = 1'b0;
        opc[2]  = OPC_JAL;       f3[2]  = 3'd0; rd[2]  = 5'd1; esel[2]  = 2'b10; ewen[2]  = 1'b1;
        opc[3]  = OPC_JALR;      f3[3]  = 3'd0; rd[3]  = 5'd1; esel[3]  = 2'b10; ewen[3]  = 1'b1;
        opc[4]  = OPC_SYSTEM;    f3[4]  = 3'd1; rd[4]  = 5'd3; esel[4]  = 2'b11; ewen[4]  = 1'b1;
        opc[5]  = OPC_SYSTEM;    f3[5]  = 3'd0; rd[5]  = 5'd5; esel[5]  = 2'b11; ewen[5]  = 1'b0;
        opc[6]  = OPC_ARI_ITYPE; f3[6]  = 3'd0; rd[6]  = 5'd0; esel[6]  = 2'b01; ewen[6]  = 1'b0;
        opc[7]  = OPC_LUI;       f3[7]  = 3'd0; rd[7]  = 5'd6; esel[7]  = 2'b01; ewen[7]  = 1'b1;
        opc[8]  = OPC_AUIPC;     f3[8]  = 3'd0; rd[8]  = 5'd7; esel[8]  = 2'b01; ewen[8]  = 1'b1;
        opc[9]  = OPC_LOAD;      f3[9]  = 3'd4; rd[9]  = 5'd8; esel[9]  = 2'b00; ewen[9]  = 1'b1;
        opc[10] = 7'h7F;         f3[10] = 3'd0; rd[10] = 5'd9; esel[10] = 2'b00; ewen[10] = 1'b0;
        do_reset();
        mem_resp_valid = 1'b1;
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, opc[i], f3[i], rd[i]);
            tick();
            checks++; if (s1_vld !== 1'b1) begin errors++; $display("FAIL dec%0d_vld got=%b exp=1", i, s1_vld); end
            checks++; if (s1_sel !== esel[i]) begin errors++; $display("FAIL dec%0d_sel got=%b exp=%b", i, s1_sel, esel[i]); end
            checks++; if (s1_wen !== ewen[i]) begin errors++; $display("FAIL dec%0d_wen got=%b exp=%b", i, s1_wen, ewen[i]); end
            checks++; if (s1_rd !== rd[i]) begin errors++; $display("FAIL dec%0d_rd got=%0d exp=%0d", i, s1_rd, rd[i]); end
            checks++; if (s1_f3 !== f3[i]) begin errors++; $display("FAIL dec%0d_f3 got=%0d exp=%0d", i, s1_f3, f3[i]); end
        end
        drive(1'b0, 7'd0, 3'd0, 5'd0);
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_load_wait();
        do_reset();
        drive(1'b1, OPC_LOAD, 3'd2, 5'd7);
        tick();
        drive(1'b0, 7'd0, 3'd0, 5'd0);
        tick();
        // Upstream presents ADDI rd=8 while the load is frozen at the head
        drive(1'b1, OPC_ARI_ITYPE, 3'd0, 5'd8);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (s2_stall !== 1'b1) begin errors++; $display("FAIL ldw_stall%0d got=%b exp=1", k, s2_stall); end
            checks++; if (s2_vld !== 1'b0) begin errors++; $display("FAIL ldw_vld%0d got=%b exp=0", k, s2_vld); end
            checks++; if (s2_wen !== 1'b0) begin errors++; $display("FAIL ldw_wen%0d got=%b exp=0", k, s2_wen); end
            tick();
        end
        mem_resp_valid = 1'b1;
        #1;
        checks++; if (s2_stall !== 1'b0) begin errors++; $display("FAIL ldw_rel_stall got=%b exp=0", s2_stall); end
        checks++; if (s2_vld !== 1'b1) begin errors++; $display("FAIL ldw_rel_vld got=%b exp=1", s2_vld); end
        checks++; if (s2_sel !== 2'b00) begin errors++; $display("FAIL ldw_rel_sel got=%b exp=00", s2_sel); end
        checks++; if (s2_wen !== 1'b1) begin errors++; $display("FAIL ldw_rel_wen got=%b exp=1", s2_wen); end
        checks++; if (s2_rd !== 5'd7) begin errors++; $display("FAIL ldw_rel_rd got=%0d exp=7", s2_rd); end
        checks++; if (s2_f3 !== 3'd2) begin errors++; $display("FAIL ldw_rel_f3 got=%0d exp=2", s2_f3); end
        tick();
        mem_resp_valid = 1'b0;
        drive(1'b0, 7'd0, 3'd0, 5'd0);
        #1;
        // The bubble that sat behind the load comes out before the ADDI
        checks++; if (s2_vld !== 1'b0) begin errors++; $display("FAIL ldw_bubble_vld got=%b exp=0", s2_vld); end
        checks++; if (s2_stall !== 1'b0) begin errors++; $display("FAIL ldw_bubble_stall got=%b exp=0", s2_stall); end
        tick();
        checks++; if (s2_vld !== 1'b1) begin errors++; $display("FAIL ldw_addi_vld got=%b exp=1", s2_vld); end
        checks++; if (s2_rd !== 5'd8) begin errors++; $display("FAIL ldw_addi_rd got=%0d exp=8", s2_rd); end
        checks++; if (s2_sel !== 2'b01) begin errors++; $display("FAIL ldw_addi_sel got=%b exp=01", s2_sel); end
    endtask

    task automatic test_back_to_back();
        logic       sv [11];
        logic [4:0] srd[11];
        logic [2:0] sf3[11];
        int         j;
        for (int i = 0; i < 11; i++) begin
            sv[i]  = (i != 8);
            srd[i] = (i < 8) ? 5'(10 + i) : 5'(11 + i);
            sf3[i] = 3'(i);
        end
        do_reset();
        for (int k = 0; k < 15; k++) begin
            if (k < 11) drive(sv[k], OPC_ARI_ITYPE, sf3[k], srd[k]);
            else        drive(1'b0, 7'd0, 3'd0, 5'd0);
            tick();
            j = k - 3;
            checks++; if (s4_stall !== 1'b0) begin errors++; $display("FAIL b2b%0d_stall got=%b exp=0", k, s4_stall); end
            if (j >= 0 && j < 11 && sv[j]) begin
                checks++; if (s4_vld !== 1'b1) begin errors++; $display("FAIL b2b%0d_vld got=%b exp=1", k, s4_vld); end
                checks++; if (s4_rd !== srd[j]) begin errors++; $display("FAIL b2b%0d_rd got=%0d exp=%0d", k, s4_rd, srd[j]); end
                checks++; if (s4_f3 !== sf3[j]) begin errors++; $display("FAIL b2b%0d_f3 got=%0d exp=%0d", k, s4_f3, sf3[j]); end
                checks++; if (s4_sel !== 2'b01) begin errors++; $display("FAIL b2b%0d_sel got=%b exp=01", k, s4_sel); end
                checks++; if (s4_wen !== 1'b1) begin errors++; $display("FAIL b2b%0d_wen got=%b exp=1", k, s4_wen); end
            end else begin
                checks++; if (s4_vld !== 1'b0) begin errors++; $display("FAIL b2b%0d_vld got=%b exp=0", k, s4_vld); end
                checks++; if (s4_wen !== 1'b0) begin errors++; $display("FAIL b2b%0d_wen got=%b exp=0", k, s4_wen); end
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, OPC_LOAD, 3'd0, 5'd11);
        tick();
        drive(1'b0, 7'd0, 3'd0, 5'd0);
        tick();
        #1;
        checks++; if (s2_stall !== 1'b1) begin errors++; $display("FAIL arst_pre_stall got=%b exp=1", s2_stall); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (s2_stall !== 1'b0) begin errors++; $display("FAIL arst_stall got=%b exp=0", s2_stall); end
        checks++; if (s2_vld !== 1'b0) begin errors++; $display("FAIL arst_vld got=%b exp=0", s2_vld); end
        checks++; if (s2_rd !== 5'd0) begin errors++; $display("FAIL arst_rd got=%0d exp=0", s2_rd); end
        tick();
        rst_n          = 1'b1;
        mem_resp_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (s2_vld !== 1'b0) begin errors++; $display("FAIL arst_post%0d_vld got=%b exp=0", k, s2_vld); end
            tick();
        end
        mem_resp_valid = 1'b0;
    endtask

`ifdef WB_CTRL_HAZARD_EN
    task automatic test_hazard();
        do_reset();
        rs1_q = 5'd9;
        rs2_q = 5'd0;
        drive(1'b1, OPC_LOAD, 3'd2, 5'd9);
        tick();
        drive(1'b0, 7'd0, 3'd0, 5'd0);
        #1;
        checks++; if ({h1_rs1, h2_rs1, h4_rs1} !== 3'b111) begin errors++; $display("FAIL haz_rs1_s0 got=%b exp=111", {h1_rs1, h2_rs1, h4_rs1}); end
        checks++; if ({h1_rs2, h2_rs2, h4_rs2} !== 3'b000) begin errors++; $display("FAIL haz_rs2_zero got=%b exp=000", {h1_rs2, h2_rs2, h4_rs2}); end
        tick();
        checks++; if ({h1_rs1, h2_rs1, h4_rs1} !== 3'b111) begin errors++; $display("FAIL haz_rs1_frozen got=%b exp=111", {h1_rs1, h2_rs1, h4_rs1}); end
        checks++; if (s2_stall !== 1'b1) begin errors++; $display("FAIL haz_stall got=%b exp=1", s2_stall); end
        rs2_q = 5'd9;
        #1;
        checks++; if ({h1_rs2, h2_rs2, h4_rs2} !== 3'b111) begin errors++; $display("FAIL haz_rs2_match got=%b exp=111", {h1_rs2, h2_rs2, h4_rs2}); end
        rs2_q          = 5'd0;
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        #1;
        // Load retired from the MEM_LAT 1/2 pipes; still in flight in MEM_LAT 4
        checks++; if ({h1_rs1, h2_rs1, h4_rs1} !== 3'b001) begin errors++; $display("FAIL haz_rs1_retired got=%b exp=001", {h1_rs1, h2_rs1, h4_rs1}); end
    endtask
`endif

    initial begin
`ifdef WB_CTRL_HAZARD_EN
        rs1_q = 5'd0;
        rs2_q = 5'd0;
`endif
        test_reset();
        test_decode();
        test_load_wait();
        test_back_to_back();
        test_async_reset();
`ifdef WB_CTRL_HAZARD_EN
        test_hazard();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
